pipe_stage_buf: RTL and testbench

- Parametrised inter-stage buffer for the five-stage pipeline. It generalises the valid/allow_in handshake used between IF/ID/EX/MEM/WB.
- DEPTH=1 behaves as a classic single pipeline latch with combinational allow_in.
- DEPTH>=2 is a decoupling FIFO with a registered allow_in. This breaks the backward allow_in timing chain and absorbs downstream stalls.
- Adds a flush (branch/exception kill) and an occupancy count, which the existing stage latches lack.

---
 rtl/pipe_stage_buf_pkg.sv | 20 ++
 rtl/pipe_stage_buf_chk.sv | 29 ++
 rtl/pipe_stage_buf_regarray.sv | 27 ++
 rtl/pipe_stage_buf.sv | 121 ++++++++++++
 tb/tb_pipe_stage_buf.sv | 150 +++++++++++++++
 5 files changed

// File: rtl/pipe_stage_buf_pkg.sv
// Shared pipeline constants: stage payload widths and the buffer depth limit.
package pipe_stage_buf_pkg;

  // Stage bus payload widths used to size pipe_stage_buf instances.
  localparam int to_ID_data_width  = 64;
  localparam int to_EX_data_width  = 150;
  localparam int to_MEM_data_width = 71;
  localparam int to_WB_data_width  = 70;
  localparam int br_data_width     = 33;

  // Largest legal buffer depth.
  localparam int PSB_MAX_DEPTH = 16;

  // Legal depths are 1 (latch) or a power of two from 2 up to PSB_MAX_DEPTH.
  function automatic bit psb_depth_ok(input int depth);
    return (depth == 1) ||
           ((depth >= 2) && (depth <= PSB_MAX_DEPTH) && ((depth & (depth - 1)) == 0));
  endfunction

endpackage

// File: rtl/pipe_stage_buf_chk.sv
// Port-level protocol checker for pipe_stage_buf (simulation/formal only).
module pipe_stage_buf_chk
  import pipe_stage_buf_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input logic             clk,
  input logic             reset,
  input logic             in_valid,
  input logic             allow_in,
  input logic             out_valid,
  input logic             out_allow_in,
  input logic             flush,
  input logic [CNT_W-1:0] count
);

  a_depth_legal: assert property (@(posedge clk) psb_depth_ok(DEPTH));

  a_count_max: assert property (@(posedge clk) disable iff (reset)
    count <= CNT_W'(DEPTH));

  a_no_push_full: assert property (@(posedge clk) disable iff (reset)
    (DEPTH > 1 && in_valid && allow_in && !flush) |-> (count != CNT_W'(DEPTH)));

  a_no_pop_empty: assert property (@(posedge clk) disable iff (reset)
    (out_valid && out_allow_in && !flush) |-> (count != {CNT_W{1'b0}}));

endmodule

// File: rtl/pipe_stage_buf_regarray.sv
// DEPTH x WIDTH register array: one synchronous write port, one asynchronous
// read port, no reset (payload is qualified by the owner's valid/count state).
module psb_regarray #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2,
  parameter int AW    = 1
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_r [DEPTH];

  // Write the addressed entry on a push.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  assign rdata = mem_r[raddr];

endmodule

// File: rtl/pipe_stage_buf.sv
// Inter-stage pipeline buffer with valid/allow_in handshake, flush and count.
// DEPTH=1 is a classic stage latch with combinational allow_in; DEPTH>=2 is a
// decoupling FIFO whose allow_in depends on registered state only.
module pipe_stage_buf
  import pipe_stage_buf_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             allow_in,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_allow_in,
  input  logic             flush,
  output logic [CNT_W-1:0] count
);

  logic push_s;
  logic pop_s;

  // Flush kills both directions of transfer in the cycle it is asserted.
  assign push_s = in_valid & allow_in & ~flush;
  assign pop_s  = out_valid & out_allow_in & ~flush;

  if (DEPTH == 1) begin : g_latch

    logic             valid_r;
    logic [WIDTH-1:0] data_r;

    // Latch handshake: accept when empty or when the held entry leaves now.
    always_comb begin
      allow_in  = ~reset & (~valid_r | out_allow_in);
      out_valid = ~reset & valid_r;
      out_data  = data_r;
      count     = CNT_W'(valid_r);
    end

    // Valid bit: reset, then flush, then push/pop.
    always_ff @(posedge clk) begin
      if (reset) begin
        valid_r <= 1'b0;
      end else if (flush) begin
        valid_r <= 1'b0;
      end else if (push_s) begin
        valid_r <= 1'b1;
      end else if (pop_s) begin
        valid_r <= 1'b0;
      end else begin
        valid_r <= valid_r;
      end
    end

    // Payload capture; not reset since it is qualified by valid_r.
    always_ff @(posedge clk) begin
      if (push_s) begin
        data_r <= in_data;
      end
    end

  end else begin : g_fifo

    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W-1:0] wr_ptr_r;
    logic [CNT_W-1:0] count_r;

    // Pointer advance modulo DEPTH.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      if (p == PTR_W'(DEPTH - 1)) begin
        return {PTR_W{1'b0}};
      end else begin
        return p + PTR_W'(1);
      end
    endfunction

    // Handshake from registered occupancy only; no path from out_allow_in.
    always_comb begin
      allow_in  = ~reset & (count_r != CNT_W'(DEPTH));
      out_valid = ~reset & (count_r != {CNT_W{1'b0}});
      count     = count_r;
    end

    psb_regarray #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH),
      .AW    (PTR_W)
    ) u_mem (
      .clk   (clk),
      .we    (push_s),
      .waddr (wr_ptr_r),
      .wdata (in_data),
      .raddr (rd_ptr_r),
      .rdata (out_data)
    );

    // Pointers and occupancy; reset and flush both empty the buffer.
    always_ff @(posedge clk) begin
      if (reset || flush) begin
        rd_ptr_r <= {PTR_W{1'b0}};
        wr_ptr_r <= {PTR_W{1'b0}};
        count_r  <= {CNT_W{1'b0}};
      end else begin
        if (push_s) begin
          wr_ptr_r <= ptr_inc(wr_ptr_r);
        end
        if (pop_s) begin
          rd_ptr_r <= ptr_inc(rd_ptr_r);
        end
        count_r <= count_r + CNT_W'(push_s) - CNT_W'(pop_s);
      end
    end

  end

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Randomised + directed bench: three buffers (DEPTH 1, 2, 4) share stimulus,
// each compared every cycle against a queue model of the handshake rules.
module tb_pipe_stage_buf;

  localparam int DEP [3] = '{1, 2, 4};

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [31:0] in_data;
  logic        out_allow_in;
  logic        flush;

  logic        ai [3];
  logic        ov [3];
  logic [31:0] od [3];
  logic [0:0]  c1;
  logic [1:0]  c2;
  logic [2:0]  c4;
  logic [31:0] cnt [3];

  int checks   = 0;
  int failures = 0;

  logic [31:0] mq [3][$];
  logic        eai [3];
  logic        eov [3];

  always #5 clk = ~clk;

  assign cnt[0] = 32'(c1);
  assign cnt[1] = 32'(c2);
  assign cnt[2] = 32'(c4);

  pipe_stage_buf #(.WIDTH(32), .DEPTH(1)) u_d1 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .allow_in(ai[0]), .out_valid(ov[0]), .out_data(od[0]),
    .out_allow_in(out_allow_in), .flush(flush), .count(c1));
  pipe_stage_buf #(.WIDTH(32), .DEPTH(2)) u_d2 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .allow_in(ai[1]), .out_valid(ov[1]), .out_data(od[1]),
    .out_allow_in(out_allow_in), .flush(flush), .count(c2));
  pipe_stage_buf #(.WIDTH(32), .DEPTH(4)) u_d4 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .allow_in(ai[2]), .out_valid(ov[2]), .out_data(od[2]),
    .out_allow_in(out_allow_in), .flush(flush), .count(c4));

  pipe_stage_buf_chk #(.DEPTH(1)) u_chk1 (.clk(clk), .reset(reset), .in_valid(in_valid),
    .allow_in(ai[0]), .out_valid(ov[0]), .out_allow_in(out_allow_in), .flush(flush), .count(c1));
  pipe_stage_buf_chk #(.DEPTH(2)) u_chk2 (.clk(clk), .reset(reset), .in_valid(in_valid),
    .allow_in(ai[1]), .out_valid(ov[1]), .out_allow_in(out_allow_in), .flush(flush), .count(c2));
  pipe_stage_buf_chk #(.DEPTH(4)) u_chk4 (.clk(clk), .reset(reset), .in_valid(in_valid),
    .allow_in(ai[2]), .out_valid(ov[2]), .out_allow_in(out_allow_in), .flush(flush), .count(c4));

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs, check outputs against the model, advance model.
  task automatic step(input logic iv, input logic [31:0] d, input logic oa,
                      input logic fl, input logic rs);
    in_valid     = iv;
    in_data      = d;
    out_allow_in = oa;
    flush        = fl;
    reset        = rs;
    #1;
    for (int k = 0; k < 3; k++) begin
      int sz;
      sz = mq[k].size();
      if (rs) eai[k] = 1'b0;
      else if (DEP[k] == 1) eai[k] = (sz == 0) || oa;
      else eai[k] = (sz < DEP[k]);
      eov[k] = !rs && (sz != 0);
      check_val($sformatf("d%0d_allow_in", DEP[k]), 32'(ai[k]), 32'(eai[k]));
      check_val($sformatf("d%0d_out_valid", DEP[k]), 32'(ov[k]), 32'(eov[k]));
      if (!rs) check_val($sformatf("d%0d_count", DEP[k]), cnt[k], 32'(sz));
      if (eov[k]) check_val($sformatf("d%0d_out_data", DEP[k]), od[k], mq[k][0]);
    end
    @(posedge clk);
    for (int k = 0; k < 3; k++) begin
      if (rs || fl) begin
        mq[k].delete();
      end else begin
        if (eov[k] && oa) void'(mq[k].pop_front());
        if (iv && eai[k]) mq[k].push_back(d);
      end
    end
    @(negedge clk);
  endtask

  initial begin
    // Reset
    step(1'b1, 32'h0, 1'b1, 1'b0, 1'b1);
    step(1'b1, 32'h0, 1'b1, 1'b0, 1'b1);
    step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

    // Streaming with downstream always ready
    step(1'b1, 32'h11, 1'b1, 1'b0, 1'b0);
    step(1'b1, 32'h22, 1'b1, 1'b0, 1'b0);
    step(1'b1, 32'h33, 1'b1, 1'b0, 1'b0);
    step(1'b0, 32'h0,  1'b1, 1'b0, 1'b0);
    step(1'b0, 32'h0,  1'b1, 1'b0, 1'b0);

    // Stall to full, hold last word upstream, then release and drain
    for (int i = 0; i < 5; i++) step(1'b1, 32'hA0 + 32'(i), 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'hA4, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 32'hA4, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

    // Wrap-around: 10 pushes, pops at 50% duty
    for (int i = 0; i < 10; i++) step(1'b1, 32'hC0 + 32'(i), 1'(i % 2), 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

    // Flush with a payload offered, then a fresh push
    for (int i = 0; i < 3; i++) step(1'b1, 32'hF0 + 32'(i), 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'hDEAD, 1'b0, 1'b1, 1'b0);
    step(1'b1, 32'hBEEF, 1'b0, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

    // Reset in mid-stream with entries held
    step(1'b1, 32'h51, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h52, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h53, 1'b0, 1'b0, 1'b1);
    step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 32'h54, 1'b1, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

    // Random traffic with alternating downstream pressure, rare flush/reset
    for (int n = 0; n < 3000; n++) begin
      logic iv, oa, fl, rs;
      iv = ($urandom_range(0, 3) != 0);
      if (((n / 250) % 2) == 0) oa = ($urandom_range(0, 3) == 0);
      else oa = ($urandom_range(0, 3) != 0);
      fl = ($urandom_range(0, 40) == 0);
      rs = ($urandom_range(0, 300) == 0);
      step(iv, $urandom, oa, fl, rs);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
